// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM state type for the RV32M divide engine.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

endpackage

// File: rtl/div_iter_core.sv
// Radix-2 restoring shift-subtract datapath on unsigned magnitudes.
// The *_nxt outputs expose the current step so the last step's result can be registered directly.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // rem < dvs always holds, so the shifted value fits XLEN+1 bits and
  // the top bit of trial is the borrow.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, dvs};
    quo_nxt = {quo[XLEN-2:0], ~trial[XLEN]};
    rem_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/muldiv_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequential engine: decode, stall control, special cases
// and sign fixup around the iterative core.
module muldiv_div_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [6:0]      opcode_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            is_muldiv_o,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

  div_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            div_op, is_unsigned, accept, b_zero, ovf;
  logic            neg_q, neg_r, rem_sel;
  logic            load, step;
  logic [XLEN-1:0] opa, opb, special_res, q_fix, r_fix, result_q;
  logic [XLEN-1:0] quo, rem, quo_nxt, rem_nxt;

  assign is_muldiv_o = (opcode_i == OPCODE_R) && (funct7_i == FUNCT7_MULDIV);
  assign div_op      = is_muldiv_o && funct3_i[2];
  assign is_unsigned = funct3_i[0];
  assign accept      = valid_i && div_op && !flush_i;

  assign opa    = (!is_unsigned && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
  assign opb    = (!is_unsigned && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
  assign b_zero = (op_b_i == '0);
  assign ovf    = !is_unsigned && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    special_res = '0;
    if (b_zero) special_res = funct3_i[1] ? op_a_i : '1;
    else        special_res = funct3_i[1] ? '0 : op_a_i;
  end

  assign q_fix = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        stall_o = accept;
        if (accept) begin
          load      = 1'b1;
          state_nxt = (b_zero || ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        step    = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      result_q <= '0;
    end else if (load) begin
      cnt     <= CW'(XLEN-1);
      rem_sel <= funct3_i[1];
      neg_q   <= !is_unsigned && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
      neg_r   <= !is_unsigned && op_a_i[XLEN-1];
      if (b_zero || ovf) result_q <= special_res;
    end else if (step && !flush_i) begin
      if (cnt == '0) result_q <= rem_sel ? r_fix : q_fix;
      else           cnt      <= cnt - 1'b1;
    end
  end

  assign result_valid_o = (state == DONE) && !flush_i;
  assign result_o       = result_q;

  div_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (load),
    .step     (step),
    .dividend (opa),
    .divisor  (opb),
    .quo      (quo),
    .rem      (rem),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

endmodule

// File: tb/tb_muldiv_div_seq.sv
// Directed + randomized bench for muldiv_div_seq against an arithmetic reference model.
module tb_muldiv_div_seq;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7  = 7'b0000001;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0, b = '0;
  logic        is_muldiv, stall, rvalid;
  logic [31:0] result;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  muldiv_div_seq #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .flush_i(flush),
    .opcode_i(opcode), .funct7_i(funct7), .funct3_i(funct3),
    .op_a_i(a), .op_b_i(b), .is_muldiv_o(is_muldiv), .stall_o(stall),
    .result_valid_o(rvalid), .result_o(result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics: truncating division, x/0 = all-ones, x%0 = x.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (y == 0) return f3[1] ? x : 32'hFFFF_FFFF;
    if (f3[0]) return f3[1] ? (x % y) : (x / y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return f3[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 1;
    if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] oa,
                        input logic [31:0] ob, input logic [31:0] exp);
    int lat, stalls, elat;
    logic got;
    elat = exp_latency(f3, oa, ob);
    @(negedge clk);
    opcode = OPC; funct7 = F7; funct3 = f3; a = oa; b = ob; valid = 1'b1;
    #1;
    lat = 0; stalls = 0; got = 1'b0;
    while (!got && lat <= XLEN + 4) begin
      if (rvalid) got = 1'b1;
      else begin
        if (stall) stalls++;
        @(negedge clk); #1;
        lat++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(elat));
    check({tag, " result"}, result, exp);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check({tag, " no_reaccept"}, {31'b0, stall | rvalid}, 32'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int seen;

    #12;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset rvalid", {31'b0, rvalid}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);
    run_op("div_m7_2",   3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_m7_2",   3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    run_op("div_7_m2",   3'b100, 32'd7, -32'sd2, 32'hFFFF_FFFD);
    run_op("rem_7_m2",   3'b110, 32'd7, -32'sd2, 32'd1);
    run_op("divu_5_0",   3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_5_0",   3'b111, 32'd5, 32'd0, 32'd5);
    run_op("div_m5_0",   3'b100, -32'sd5, 32'd0, 32'hFFFF_FFFF);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    for (int i = 0; i < 24; i++) begin
      rf3 = 3'b100 | 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 0) begin ra = 32'hFFFF_FFFF; rb = 32'd1; end
      if (i == 1) begin ra = 32'd3; rb = 32'hFFFF_FFFF; end
      run_op($sformatf("rand%0d", i), rf3, ra, rb, model(rf3, ra, rb));
    end

    // Abort mid-calculation
    @(negedge clk);
    opcode = OPC; funct7 = F7; funct3 = 3'b101; a = 32'd100; b = 32'd7; valid = 1'b1;
    #1 check("flush accept stall", {31'b0, stall}, 32'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1; valid = 1'b0;
    #1 check("flush cycle rvalid", {31'b0, rvalid}, 32'd0);
    @(negedge clk); flush = 1'b0;
    #1 check("flush after stall", {31'b0, stall}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (rvalid || stall) seen++;
    end
    check("flush no result", 32'(seen), 32'd0);
    run_op("divu_9_3_after_flush", 3'b101, 32'd9, 32'd3, 32'd3);

    // Flush in the accept cycle suppresses acceptance
    @(negedge clk);
    funct3 = 3'b101; a = 32'd50; b = 32'd5; valid = 1'b1; flush = 1'b1;
    #1 check("flush_accept stall", {31'b0, stall}, 32'd0);
    @(negedge clk); valid = 1'b0; flush = 1'b0;
    #1 check("flush_accept idle", {31'b0, stall | rvalid}, 32'd0);

    // MUL-class is decoded but ignored
    @(negedge clk);
    funct3 = 3'b000; a = 32'd6; b = 32'd7; valid = 1'b1;
    #1;
    check("mul is_muldiv", {31'b0, is_muldiv}, 32'd1);
    check("mul stall", {31'b0, stall}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (rvalid || stall) seen++;
    end
    check("mul no activity", 32'(seen), 32'd0);
    valid = 1'b0;

    // Async reset mid-calculation
    @(negedge clk);
    funct3 = 3'b101; a = 32'd1000; b = 32'd3; valid = 1'b1;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst stall", {31'b0, stall}, 32'd0);
    check("rst rvalid", {31'b0, rvalid}, 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("divu_after_reset", 3'b101, 32'd1000, 32'd3, 32'd333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
